// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, fetch FSM states and the reset vector.
package cpu_pkg;

    localparam int CPU_AW        = 8;
    localparam int CPU_IW        = 16;
    localparam int FETCH_TIMEOUT = 15;

    localparam int unsigned RESET_VECTOR = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Lost-request watchdog for the fetch unit; only built when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_ctr
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = FETCH_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Fires on the TIMEOUT-th consecutive waiting cycle; an ack in that cycle wins.
    assign expired = run && !clear && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || !run || clear || expired) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC -> memory req/ack -> decoder valid/ready, with branch squash.
// Optional lost-request retry is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int AW      = CPU_AW,
    parameter int IW      = CPU_IW,
    parameter int TIMEOUT = FETCH_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic [AW-1:0] next_pc,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [IW-1:0] mem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          fetch_err
);

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

    fetch_state_t  state;
    logic [AW-1:0] fa;
    logic          ack_ok;
    logic          timeout_hit;

    assign fa      = branch_taken ? branch_target : pc;
    assign ack_ok  = (state == REQ) && mem_req && mem_ack && !branch_taken;
    assign next_pc = branch_taken ? branch_target : (ack_ok ? pc + AW'(1) : pc);

`ifdef FETCH_TIMEOUT_EN
    logic expired;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .run     (((state == REQ) || (state == FLUSH)) && mem_req),
        .clear   (mem_ack),
        .expired (expired)
    );

    assign timeout_hit = expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch reads the pre-edge values of state, mem_req and mem_addr.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= AW'(RESET_VECTOR);
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= AW'(RESET_VECTOR);
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    mem_addr <= fa;
                    mem_req  <= 1'b1;
                end
                REQ: begin
                    if (!mem_req) begin
                        // Re-issue after a timeout gap, following any redirect seen meanwhile.
                        mem_req <= 1'b1;
                        if (branch_taken) mem_addr <= branch_target;
                    end else if (mem_ack) begin
                        if (branch_taken) begin
                            mem_addr <= branch_target;
                        end else begin
                            instr       <= mem_rdata;
                            instr_pc    <= mem_addr;
                            instr_valid <= 1'b1;
                            mem_req     <= 1'b0;
                            state       <= HOLD;
                        end
                    end else if (branch_taken) begin
                        state <= FLUSH;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (mem_ack) begin
                        mem_addr <= fa;
                        state    <= REQ;
                    end else if (timeout_hit) begin
                        mem_req  <= 1'b0;
                        mem_addr <= fa;
                        state    <= REQ;
                    end
                end
                HOLD: begin
                    // fa already selects the branch target, which outranks instr_ready.
                    if (branch_taken || instr_ready) begin
                        instr_valid <= 1'b0;
                        mem_addr    <= fa;
                        mem_req     <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; covers FETCH_TIMEOUT_EN when defined.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc;
    logic [7:0]  next_pc;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        fetch_err;

    int compared   = 0;
    int mismatched = 0;

    instr_fetch_unit #(.AW(8), .IW(16), .TIMEOUT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .next_pc       (next_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_cycle(input logic [15:0] data, input logic [7:0] exp_next);
        mem_ack   = 1'b1;
        mem_rdata = data;
        #1;
        check("next_pc_on_ack", next_pc, exp_next);
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    task automatic hold_check(input logic [15:0] data, input logic [7:0] ipc);
        check("hold_instr", instr, data);
        check("hold_instr_pc", instr_pc, ipc);
        check("hold_valid", instr_valid, 1'b1);
        check("hold_mem_req", mem_req, 1'b0);
    endtask

    task automatic issue_check(input logic [7:0] addr);
        check("issue_mem_req", mem_req, 1'b1);
        check("issue_mem_addr", mem_addr, addr);
        check("issue_valid", instr_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; pc = 8'h00; branch_taken = 1'b0; branch_target = 8'h00;
        mem_ack = 1'b0; mem_rdata = 16'h0000; instr_ready = 1'b0;
        cyc(); cyc();
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 16'h0000);
        check("rst_instr_pc", instr_pc, 8'h00);
        check("rst_fetch_err", fetch_err, 1'b0);

        // Sequential fetches at 0x00..0x02 with one wait cycle before each ack.
        reset = 1'b0;
        #1;
        check("idle_next_pc", next_pc, 8'h00);
        cyc();
        issue_check(8'h00);
        cyc();
        check("wait_mem_req", mem_req, 1'b1);
        check("wait_next_pc", next_pc, 8'h00);
        ack_cycle(16'h1000, 8'h01);
        pc = 8'h01;
        hold_check(16'h1000, 8'h00);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        issue_check(8'h01);
        cyc();
        ack_cycle(16'h1001, 8'h02);
        pc = 8'h02;
        hold_check(16'h1001, 8'h01);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        issue_check(8'h02);
        cyc();
        ack_cycle(16'h1002, 8'h03);
        pc = 8'h03;
        hold_check(16'h1002, 8'h02);

        // PC wrap at 0xFF.
        pc = 8'hFF;
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        issue_check(8'hFF);
        ack_cycle(16'h10FF, 8'h00);
        pc = 8'h00;
        hold_check(16'h10FF, 8'hFF);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        issue_check(8'h00);

        // Branch while the request is pending: flush, discard stale data, refetch at 0x40.
        branch_taken = 1'b1; branch_target = 8'h40;
        #1;
        check("branch_next_pc", next_pc, 8'h40);
        cyc();
        branch_taken = 1'b0;
        pc = 8'h40;
        check("flush_mem_req", mem_req, 1'b1);
        check("flush_mem_addr", mem_addr, 8'h00);
        check("flush_valid", instr_valid, 1'b0);
        cyc();
        check("flush_wait_valid", instr_valid, 1'b0);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        #1;
        check("flush_ack_next_pc", next_pc, 8'h40);
        cyc();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        issue_check(8'h40);
        check("stale_instr", instr, 16'h10FF);
        ack_cycle(16'h1040, 8'h41);
        pc = 8'h41;
        hold_check(16'h1040, 8'h40);

        // Decoder stall: outputs frozen for five cycles.
        for (int i = 0; i < 5; i++) begin
            cyc();
            hold_check(16'h1040, 8'h40);
            check("stall_next_pc", next_pc, 8'h41);
        end

        // Branch together with instr_ready drops the held word.
        branch_taken = 1'b1; branch_target = 8'h80; instr_ready = 1'b1;
        #1;
        check("hold_branch_next_pc", next_pc, 8'h80);
        cyc();
        branch_taken = 1'b0; instr_ready = 1'b0;
        pc = 8'h80;
        issue_check(8'h80);

        // Reset while a request is outstanding.
        reset = 1'b1;
        cyc();
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_valid", instr_valid, 1'b0);
        check("midrst_mem_addr", mem_addr, 8'h00);
        reset = 1'b0;
        pc = 8'h22;
        cyc();
        issue_check(8'h22);

        // Branch coinciding with ack: data dropped, stays in REQ at the target.
        mem_ack = 1'b1; mem_rdata = 16'hBEEF; branch_taken = 1'b1; branch_target = 8'h55;
        #1;
        check("brack_next_pc", next_pc, 8'h55);
        cyc();
        mem_ack = 1'b0; mem_rdata = 16'h0000; branch_taken = 1'b0;
        pc = 8'h55;
        issue_check(8'h55);
        check("brack_instr", instr, 16'h0000);
        ack_cycle(16'h1055, 8'h56);
        pc = 8'h56;
        hold_check(16'h1055, 8'h55);

        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        issue_check(8'h56);
`ifdef FETCH_TIMEOUT_EN
        // Memory never acks: 15th waiting cycle expires, one-cycle gap, same address retried.
        for (int i = 0; i < 14; i++) begin
            cyc();
            check("to_wait_mem_req", mem_req, 1'b1);
            check("to_wait_err", fetch_err, 1'b0);
        end
        cyc();
        check("to_err_pulse", fetch_err, 1'b1);
        check("to_gap_mem_req", mem_req, 1'b0);
        check("to_gap_mem_addr", mem_addr, 8'h56);
        cyc();
        check("to_err_clear", fetch_err, 1'b0);
        issue_check(8'h56);
`else
        // No watchdog: the request simply stays up.
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("nto_mem_req", mem_req, 1'b1);
            check("nto_err", fetch_err, 1'b0);
        end
`endif
        ack_cycle(16'h1056, 8'h57);
        pc = 8'h57;
        hold_check(16'h1056, 8'h56);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
